// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte receive link and instruction RAM write port for imem_loader
//
// Purpose: bundles the host byte stream (rx_data/rx_valid/rx_ready) and the
// instruction RAM write port (wr_en/wr_addr/wr_data) used by imem_loader.
// Ports:
//   rx_data   8           incoming byte from the host link
//   rx_valid  1           rx_data valid this cycle
//   rx_ready  1           loader accepts a byte this cycle
//   wr_en     1           one-cycle RAM write strobe
//   wr_addr   ADDR_WIDTH  word-aligned byte address
//   wr_data   DATA_WIDTH  instruction word
// Modports: master = host link and RAM side, slave = loader side.

interface imem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader for the RV32I instruction memory
//
// Purpose: receives a frame (16-bit little-endian word count, little-endian
// instruction bytes, XOR checksum of the data bytes), writes one word per
// four data bytes to the instruction RAM and holds the CPU in reset until a
// clean checksum has been received.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   begin a load (honoured in IDLE, DONE, ERROR)
//   bus        if   slave side: rx_data/rx_valid/rx_ready, wr_en/wr_addr/wr_data
//   cpu_hold   out  CPU must stay in reset
//   load_done  out  image loaded and checksum matched (held)
//   load_err   out  checksum mismatch or oversize image (held)

module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERROR} state_t;

  localparam logic [15:0] MEM_WORDS = 16'(MEM_SIZE);

  state_t      state, state_next;
  logic [15:0] count;
  logic [15:0] word_index;
  logic [1:0]  byte_lane;
  logic [7:0]  csum;
  logic [23:0] word_buf;     // lanes 0..2; lane 3 comes straight from rx_data

  logic        accept;
  logic [15:0] hdr_count;
  logic        last_word;
  logic        receiving_next;

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign hdr_count = {bus.rx_data, count[7:0]};
  assign last_word = (word_index == count - 16'd1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = HDR0;
      HDR0: if (accept) state_next = HDR1;
      HDR1: begin
        if (accept) begin
          if (hdr_count > MEM_WORDS)  state_next = ERROR;
          else if (hdr_count == 16'd0) state_next = CSUM;
          else                         state_next = DATA;
        end
      end
      DATA: if (accept && byte_lane == 2'd3 && last_word) state_next = CSUM;
      CSUM: if (accept) state_next = (bus.rx_data == csum) ? DONE : ERROR;
      default: state_next = IDLE;
    endcase
  end

  // rx_ready is registered from the next state so it tracks state exactly.
  assign receiving_next = (state_next == HDR0) || (state_next == HDR1) ||
                          (state_next == DATA) || (state_next == CSUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      count        <= '0;
      word_index   <= '0;
      byte_lane    <= '0;
      csum         <= '0;
      word_buf     <= '0;
    end else begin
      state        <= state_next;
      bus.rx_ready <= receiving_next;
      bus.wr_en    <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            cpu_hold   <= 1'b1;
            word_index <= '0;
            byte_lane  <= '0;
            csum       <= '0;
          end
        end
        HDR0: if (accept) count[7:0] <= bus.rx_data;
        HDR1: begin
          if (accept) begin
            count[15:8] <= bus.rx_data;
            if (hdr_count > MEM_WORDS) load_err <= 1'b1;
          end
        end
        DATA: begin
          if (accept) begin
            csum      <= csum ^ bus.rx_data;
            byte_lane <= byte_lane + 2'd1;
            case (byte_lane)
              2'd0: word_buf[7:0]   <= bus.rx_data;
              2'd1: word_buf[15:8]  <= bus.rx_data;
              2'd2: word_buf[23:16] <= bus.rx_data;
              default: begin
                bus.wr_data <= DATA_WIDTH'({bus.rx_data, word_buf});
                bus.wr_addr <= ADDR_WIDTH'({word_index, 2'b00});
                bus.wr_en   <= 1'b1;
                word_index  <= word_index + 16'd1;
              end
            endcase
          end
        end
        CSUM: begin
          if (accept) begin
            if (bus.rx_data == csum) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_err  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic cpu_hold, load_done, load_err;

  imem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(512)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit gap_mode = 1'b0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  // Record every RAM write; values sampled here are the ones held during wr_en.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (gap_mode) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
    end
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    n = 0;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_nominal(input logic [7:0] cs);
    logic [7:0] frame [11];
    frame = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00, 8'h00};
    frame[10] = cs;
    for (int i = 0; i < 11; i++) send_byte(frame[i]);
    end_frame();
  endtask

  task automatic check_nominal_writes(input string tag);
    check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
    if (wa_q.size() == 2) begin
      check({tag, "_addr0"}, wa_q[0], 32'h0);
      check({tag, "_data0"}, wd_q[0], 32'h0000_0513);
      check({tag, "_addr1"}, wa_q[1], 32'h4);
      check({tag, "_data1"}, wd_q[1], 32'h0000_8067);
    end
  endtask

  initial begin
    int errs;
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_rx_ready",  32'(bus.rx_ready), 32'd0);
    check("rst_wr_en",     32'(bus.wr_en),    32'd0);
    check("rst_cpu_hold",  32'(cpu_hold),     32'd0);
    check("rst_load_done", 32'(load_done),    32'd0);
    check("rst_load_err",  32'(load_err),     32'd0);
    check("rst_wr_addr",   bus.wr_addr,       32'd0);
    check("rst_wr_data",   bus.wr_data,       32'd0);

    // Nominal load
    wa_q.delete(); wd_q.delete();
    do_start();
    check("nom_rx_ready_after_start", 32'(bus.rx_ready), 32'd1);
    check("nom_hold_after_start",     32'(cpu_hold),     32'd1);
    send_nominal(8'hF1);
    check_nominal_writes("nom");
    check("nom_done", 32'(load_done), 32'd1);
    check("nom_hold", 32'(cpu_hold),  32'd0);
    check("nom_err",  32'(load_err),  32'd0);

    // Bad checksum
    wa_q.delete(); wd_q.delete();
    do_start();
    send_nominal(8'h00);
    check_nominal_writes("badcs");
    check("badcs_err",      32'(load_err),     32'd1);
    check("badcs_done",     32'(load_done),    32'd0);
    check("badcs_hold",     32'(cpu_hold),     32'd1);
    check("badcs_rx_ready", 32'(bus.rx_ready), 32'd0);

    // Empty image
    wa_q.delete(); wd_q.delete();
    do_start();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    end_frame();
    check("empty_nwr",  32'(wa_q.size()), 32'd0);
    check("empty_done", 32'(load_done),   32'd1);
    check("empty_err",  32'(load_err),    32'd0);
    check("empty_hold", 32'(cpu_hold),    32'd0);

    // Oversize image (513 words), then recovery
    wa_q.delete(); wd_q.delete();
    do_start();
    send_byte(8'h01); send_byte(8'h02);
    end_frame();
    check("over_err",      32'(load_err),     32'd1);
    check("over_done",     32'(load_done),    32'd0);
    check("over_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("over_hold",     32'(cpu_hold),     32'd1);
    repeat (4) @(negedge clk);
    check("over_nwr", 32'(wa_q.size()), 32'd0);
    do_start();
    check("recover_err_cleared", 32'(load_err), 32'd0);
    send_nominal(8'hF1);
    check_nominal_writes("recover");
    check("recover_done", 32'(load_done), 32'd1);

    // Gapped rx_valid
    wa_q.delete(); wd_q.delete();
    gap_mode = 1'b1;
    do_start();
    send_nominal(8'hF1);
    gap_mode = 1'b0;
    check_nominal_writes("gap");
    check("gap_done", 32'(load_done), 32'd1);
    check("gap_hold", 32'(cpu_hold),  32'd0);

    // Reset after 6 data bytes
    wa_q.delete(); wd_q.delete();
    do_start();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h05); send_byte(8'h00);
    send_byte(8'h00); send_byte(8'h67); send_byte(8'h80);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rx_ready",  32'(bus.rx_ready), 32'd0);
    check("mid_wr_en",     32'(bus.wr_en),    32'd0);
    check("mid_cpu_hold",  32'(cpu_hold),     32'd0);
    check("mid_load_done", 32'(load_done),    32'd0);
    check("mid_load_err",  32'(load_err),     32'd0);
    check("mid_wr_addr",   bus.wr_addr,       32'd0);
    check("mid_wr_data",   bus.wr_data,       32'd0);
    repeat (6) @(negedge clk);
    check("mid_rx_ready_idle", 32'(bus.rx_ready), 32'd0);
    check("mid_nwr", 32'(wa_q.size()), 32'd1);
    if (wa_q.size() >= 1) check("mid_addr0", wa_q[0], 32'h0);

    // Full capacity: 512 words, data = index; checksum of that image is 0x00
    wa_q.delete(); wd_q.delete();
    do_start();
    send_byte(8'h00); send_byte(8'h02);
    for (int i = 0; i < 512; i++) begin
      logic [15:0] w;
      w = 16'(i);
      send_byte(w[7:0]); send_byte(w[15:8]); send_byte(8'h00); send_byte(8'h00);
    end
    send_byte(8'h00);
    end_frame();
    check("full_nwr", 32'(wa_q.size()), 32'd512);
    errs = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] !== 32'(i * 4) || wd_q[i] !== 32'(i)) errs++;
    end
    check("full_word_errs", 32'(errs), 32'd0);
    if (wa_q.size() == 512) begin
      check("full_last_addr", wa_q[511], 32'h0000_07FC);
      check("full_last_data", wd_q[511], 32'h0000_01FF);
    end
    check("full_done", 32'(load_done), 32'd1);
    check("full_err",  32'(load_err),  32'd0);
    check("full_hold", 32'(cpu_hold),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
